// File: rtl/fill_tracker_if.sv
`default_nettype none
// ============================================================================
// fill_tracker_if : bank / memory handshake bundle for the line-fill tracker
// Rev 1.0
// ============================================================================
interface fill_tracker_if #(
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int LINE_SIZE       = 64,
  parameter int NUM_ENTRIES     = 4
);
  localparam int TAG_WIDTH  = $clog2(NUM_ENTRIES);
  localparam int CNT_WIDTH  = $clog2(NUM_ENTRIES + 1);
  localparam int DATA_WIDTH = 8 * LINE_SIZE;

  logic                       fill_req_valid;
  logic [LINE_ADDR_WIDTH-1:0] fill_req_addr;
  logic                       fill_req_ready;
  logic                       mem_req_valid;
  logic [LINE_ADDR_WIDTH-1:0] mem_req_addr;
  logic [TAG_WIDTH-1:0]       mem_req_tag;
  logic                       mem_req_ready;
  logic                       mem_rsp_valid;
  logic [TAG_WIDTH-1:0]       mem_rsp_tag;
  logic [DATA_WIDTH-1:0]      mem_rsp_data;
  logic                       mem_rsp_ready;
  logic                       fill_valid;
  logic [LINE_ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0]      fill_data;
  logic                       fill_ready;
  logic                       lookup_ready;
  logic [LINE_ADDR_WIDTH-1:0] lookup_addr;
  logic [CNT_WIDTH-1:0]       pending_count;

  // master = the tracker, slave = bank + memory environment
  modport master (
    input  fill_req_valid, fill_req_addr, mem_req_ready,
    input  mem_rsp_valid, mem_rsp_tag, mem_rsp_data, fill_ready,
    output fill_req_ready, mem_req_valid, mem_req_addr, mem_req_tag,
    output mem_rsp_ready, fill_valid, fill_addr, fill_data,
    output lookup_ready, lookup_addr, pending_count
  );

  modport slave (
    output fill_req_valid, fill_req_addr, mem_req_ready,
    output mem_rsp_valid, mem_rsp_tag, mem_rsp_data, fill_ready,
    input  fill_req_ready, mem_req_valid, mem_req_addr, mem_req_tag,
    input  mem_rsp_ready, fill_valid, fill_addr, fill_data,
    input  lookup_ready, lookup_addr, pending_count
  );
endinterface
`default_nettype wire

// File: rtl/fill_tracker.sv
`default_nettype none
// ============================================================================
// fill_tracker : per-bank line-fill tracker (merge, issue, tag-match, deliver)
// Rev 1.0
// ============================================================================
module fill_tracker #(
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int LINE_SIZE       = 64,
  parameter int NUM_ENTRIES     = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fill_tracker_if.master     bus
);
  localparam int TAG_WIDTH  = $clog2(NUM_ENTRIES);
  localparam int CNT_WIDTH  = $clog2(NUM_ENTRIES + 1);
  localparam int DATA_WIDTH = 8 * LINE_SIZE;

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_INFLIGHT = 2'd2,
    ST_FILLED   = 2'd3
  } state_t;

  state_t                     r_state [NUM_ENTRIES];
  logic [LINE_ADDR_WIDTH-1:0] r_addr  [NUM_ENTRIES];
  logic                       r_lock_valid;
  logic [TAG_WIDTH-1:0]       r_lock_idx;
  logic                       r_fill_valid;
  logic [LINE_ADDR_WIDTH-1:0] r_fill_addr;
  logic [DATA_WIDTH-1:0]      r_fill_data;
  logic [TAG_WIDTH-1:0]       r_fill_idx;
  logic [CNT_WIDTH-1:0]       r_pending;

  logic                 w_hit;
  logic                 w_free_any;
  logic [TAG_WIDTH-1:0] w_free_idx;
  logic                 w_wait_any;
  logic [TAG_WIDTH-1:0] w_wait_idx;
  logic [TAG_WIDTH-1:0] w_sel_idx;
  logic                 w_mreq_valid;
  logic                 w_mreq_fire;
  logic                 w_alloc;
  logic                 w_rsp_ready;
  logic                 w_rsp_fire;
  logic                 w_rsp_hit;
  logic                 w_fill_fire;

  // Descending scan so the lowest matching index wins the last write.
  always_comb begin
    w_hit      = 1'b0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_wait_any = 1'b0;
    w_wait_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_state[i] == ST_FREE) begin
        w_free_any = 1'b1;
        w_free_idx = TAG_WIDTH'(i);
      end
      if (r_state[i] == ST_WAIT) begin
        w_wait_any = 1'b1;
        w_wait_idx = TAG_WIDTH'(i);
      end
      if (((r_state[i] == ST_WAIT) || (r_state[i] == ST_INFLIGHT)) &&
          (r_addr[i] == bus.fill_req_addr)) begin
        w_hit = 1'b1;
      end
    end
  end

  // A stalled request stays locked to its entry so a newly allocated
  // lower-index WAIT entry cannot swap the address under the memory port.
  assign w_sel_idx    = r_lock_valid ? r_lock_idx : w_wait_idx;
  assign w_mreq_valid = r_lock_valid | w_wait_any;
  assign w_mreq_fire  = w_mreq_valid & bus.mem_req_ready;
  assign w_alloc      = bus.fill_req_valid & ~w_hit & w_free_any;
  assign w_rsp_ready  = ~r_fill_valid | bus.fill_ready;
  assign w_rsp_fire   = bus.mem_rsp_valid & w_rsp_ready;
  assign w_rsp_hit    = w_rsp_fire & (r_state[bus.mem_rsp_tag] == ST_INFLIGHT);
  assign w_fill_fire  = r_fill_valid & bus.fill_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_state[i] <= ST_FREE;
        r_addr[i]  <= '0;
      end
      r_lock_valid <= 1'b0;
      r_lock_idx   <= '0;
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_data  <= '0;
      r_fill_idx   <= '0;
      r_pending    <= '0;
    end else begin
      // The four updates always target entries in distinct states.
      if (w_alloc) begin
        r_state[w_free_idx] <= ST_WAIT;
        r_addr[w_free_idx]  <= bus.fill_req_addr;
      end
      if (w_mreq_fire) begin
        r_state[w_sel_idx] <= ST_INFLIGHT;
      end
      if (w_rsp_hit) begin
        r_state[bus.mem_rsp_tag] <= ST_FILLED;
      end
      if (w_fill_fire) begin
        r_state[r_fill_idx] <= ST_FREE;
      end

      if (w_mreq_fire) begin
        r_lock_valid <= 1'b0;
      end else if (w_mreq_valid) begin
        r_lock_valid <= 1'b1;
        r_lock_idx   <= w_sel_idx;
      end

      if (w_rsp_hit) begin
        r_fill_valid <= 1'b1;
        r_fill_addr  <= r_addr[bus.mem_rsp_tag];
        r_fill_data  <= bus.mem_rsp_data;
        r_fill_idx   <= bus.mem_rsp_tag;
      end else if (w_fill_fire) begin
        r_fill_valid <= 1'b0;
      end

      case ({w_alloc, w_fill_fire})
        2'b10:   r_pending <= r_pending + CNT_WIDTH'(1);
        2'b01:   r_pending <= r_pending - CNT_WIDTH'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign bus.fill_req_ready = w_hit | w_free_any;
  assign bus.mem_req_valid  = w_mreq_valid;
  assign bus.mem_req_addr   = w_mreq_valid ? r_addr[w_sel_idx] : '0;
  assign bus.mem_req_tag    = w_mreq_valid ? w_sel_idx : '0;
  assign bus.mem_rsp_ready  = w_rsp_ready;
  assign bus.fill_valid     = r_fill_valid;
  assign bus.fill_addr      = r_fill_addr;
  assign bus.fill_data      = r_fill_data;
  assign bus.lookup_ready   = w_fill_fire;
  assign bus.lookup_addr    = r_fill_addr;
  assign bus.pending_count  = r_pending;

`ifndef SYNTHESIS
  a_rsp_tag_inflight: assert property (@(posedge clk) disable iff (!reset)
    w_rsp_fire |-> (r_state[bus.mem_rsp_tag] == ST_INFLIGHT))
    else $error("fill_tracker: response for tag %0d which is not in flight", bus.mem_rsp_tag);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fill_tracker.sv
`default_nettype none
// ============================================================================
// tb_fill_tracker : directed vector table plus multi-cycle corner sequences
// Rev 1.0
// ============================================================================
module tb_fill_tracker;
  localparam int AW = 26;
  localparam int NV = 23;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fill_tracker_if #(.LINE_ADDR_WIDTH(AW), .LINE_SIZE(64), .NUM_ENTRIES(4)) bus ();

  fill_tracker #(.LINE_ADDR_WIDTH(AW), .LINE_SIZE(64), .NUM_ENTRIES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic          rv;   logic [AW-1:0] ra;   logic          mr;
    logic          sv;   logic [1:0]    st;   logic [31:0]   sd;
    logic          fr;
    logic          e_rr; logic          e_mv; logic [AW-1:0] e_ma;
    logic [1:0]    e_mt; logic          e_rspr; logic        e_fv;
    logic [AW-1:0] e_fa; logic [31:0]   e_fd; logic          e_lr;
    logic [2:0]    e_pc;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic rv, input logic [AW-1:0] ra, input logic mr,
    input logic sv, input logic [1:0] st, input logic [31:0] sd, input logic fr,
    input logic e_rr, input logic e_mv, input logic [AW-1:0] e_ma, input logic [1:0] e_mt,
    input logic e_rspr, input logic e_fv, input logic [AW-1:0] e_fa, input logic [31:0] e_fd,
    input logic e_lr, input logic [2:0] e_pc);
    vec_t v;
    v.rv = rv; v.ra = ra; v.mr = mr; v.sv = sv; v.st = st; v.sd = sd; v.fr = fr;
    v.e_rr = e_rr; v.e_mv = e_mv; v.e_ma = e_ma; v.e_mt = e_mt; v.e_rspr = e_rspr;
    v.e_fv = e_fv; v.e_fa = e_fa; v.e_fd = e_fd; v.e_lr = e_lr; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.fill_req_valid = v.rv;
    bus.fill_req_addr  = v.ra;
    bus.mem_req_ready  = v.mr;
    bus.mem_rsp_valid  = v.sv;
    bus.mem_rsp_tag    = v.st;
    bus.mem_rsp_data   = {16{v.sd}};
    bus.fill_ready     = v.fr;
  endtask

  task automatic idle();
    bus.fill_req_valid = 1'b0;
    bus.fill_req_addr  = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_tag    = '0;
    bus.mem_rsp_data   = '0;
    bus.fill_ready     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [61:0]  act_ctl;
    logic [61:0]  exp_ctl;
    logic [25:0]  tag_addr [4];
    int           ord [4];
    logic [25:0]  qa [$];
    logic [511:0] qd [$];
    int           ri;
    int           nf;
    int           cyc;

    //            rv  ra     mr sv st sd            fr | rr mv ma     mt rr fv fa     fd            lr pc
    vecs[0]  = mk(0, 26'h0,   0, 0, 0, 32'h0,        0,  1, 0, 26'h0,   0, 1, 0, 26'h0,  32'h0,        0, 0);
    vecs[1]  = mk(1, 26'h100, 0, 0, 0, 32'h0,        0,  1, 0, 26'h0,   0, 1, 0, 26'h0,  32'h0,        0, 0);
    vecs[2]  = mk(0, 26'h0,   0, 0, 0, 32'h0,        0,  1, 1, 26'h100, 0, 1, 0, 26'h0,  32'h0,        0, 1);
    vecs[3]  = mk(1, 26'h100, 1, 0, 0, 32'h0,        0,  1, 1, 26'h100, 0, 1, 0, 26'h0,  32'h0,        0, 1);
    vecs[4]  = mk(1, 26'h100, 1, 0, 0, 32'h0,        0,  1, 0, 26'h0,   0, 1, 0, 26'h0,  32'h0,        0, 1);
    vecs[5]  = mk(0, 26'h0,   0, 1, 0, 32'hA5A50001, 0,  1, 0, 26'h0,   0, 1, 0, 26'h0,  32'h0,        0, 1);
    vecs[6]  = mk(0, 26'h0,   0, 0, 0, 32'h0,        1,  1, 0, 26'h0,   0, 1, 1, 26'h100,32'hA5A50001, 1, 1);
    vecs[7]  = mk(0, 26'h0,   0, 0, 0, 32'h0,        0,  1, 0, 26'h0,   0, 1, 0, 26'h0,  32'h0,        0, 0);
    vecs[8]  = mk(1, 26'h10,  1, 0, 0, 32'h0,        0,  1, 0, 26'h0,   0, 1, 0, 26'h0,  32'h0,        0, 0);
    vecs[9]  = mk(1, 26'h11,  1, 0, 0, 32'h0,        0,  1, 1, 26'h10,  0, 1, 0, 26'h0,  32'h0,        0, 1);
    vecs[10] = mk(1, 26'h12,  1, 0, 0, 32'h0,        0,  1, 1, 26'h11,  1, 1, 0, 26'h0,  32'h0,        0, 2);
    vecs[11] = mk(1, 26'h13,  1, 0, 0, 32'h0,        0,  1, 1, 26'h12,  2, 1, 0, 26'h0,  32'h0,        0, 3);
    vecs[12] = mk(1, 26'h14,  1, 0, 0, 32'h0,        0,  0, 1, 26'h13,  3, 1, 0, 26'h0,  32'h0,        0, 4);
    vecs[13] = mk(1, 26'h14,  1, 0, 0, 32'h0,        0,  0, 0, 26'h0,   0, 1, 0, 26'h0,  32'h0,        0, 4);
    vecs[14] = mk(1, 26'h11,  1, 0, 0, 32'h0,        0,  1, 0, 26'h0,   0, 1, 0, 26'h0,  32'h0,        0, 4);
    vecs[15] = mk(1, 26'h14,  1, 1, 2, 32'h22220000, 0,  0, 0, 26'h0,   0, 1, 0, 26'h0,  32'h0,        0, 4);
    vecs[16] = mk(1, 26'h14,  1, 1, 1, 32'h11110000, 0,  0, 0, 26'h0,   0, 0, 1, 26'h12, 32'h22220000, 0, 4);
    vecs[17] = mk(1, 26'h14,  1, 1, 1, 32'h11110000, 1,  0, 0, 26'h0,   0, 1, 1, 26'h12, 32'h22220000, 1, 4);
    vecs[18] = mk(1, 26'h14,  0, 0, 0, 32'h0,        0,  1, 0, 26'h0,   0, 0, 1, 26'h11, 32'h11110000, 0, 3);
    vecs[19] = mk(0, 26'h0,   0, 0, 0, 32'h0,        0,  0, 1, 26'h14,  2, 0, 1, 26'h11, 32'h11110000, 0, 4);
    vecs[20] = mk(1, 26'h11,  1, 0, 0, 32'h0,        1,  0, 1, 26'h14,  2, 1, 1, 26'h11, 32'h11110000, 1, 4);
    vecs[21] = mk(1, 26'h11,  1, 0, 0, 32'h0,        0,  1, 0, 26'h0,   0, 1, 0, 26'h0,  32'h0,        0, 3);
    vecs[22] = mk(0, 26'h0,   1, 0, 0, 32'h0,        0,  0, 1, 26'h11,  1, 1, 0, 26'h0,  32'h0,        0, 4);

    idle();
    #1;
    chk("rst.fill_addr",  512'(bus.fill_addr), 512'(0));
    chk("rst.fill_data",  bus.fill_data, 512'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single fill, merges, full table, backpressure and FILLED-not-merged
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      apply(vecs[k]);
      #1;
      act_ctl = {bus.fill_req_ready, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_tag,
                 bus.mem_rsp_ready, bus.fill_valid, (bus.fill_valid ? bus.fill_addr : 26'h0),
                 bus.lookup_ready, bus.pending_count};
      exp_ctl = {vecs[k].e_rr, vecs[k].e_mv, vecs[k].e_ma, vecs[k].e_mt, vecs[k].e_rspr,
                 vecs[k].e_fv, vecs[k].e_fa, vecs[k].e_lr, vecs[k].e_pc};
      chk($sformatf("vec%0d.ctl", k), 512'(act_ctl), 512'(exp_ctl));
      if (vecs[k].e_fv) begin
        chk($sformatf("vec%0d.data", k), bus.fill_data, {16{vecs[k].e_fd}});
      end
    end

    // Out-of-order responses 3,1,0,2 against a toggling fill_ready
    tag_addr = '{26'h10, 26'h11, 26'h14, 26'h13};
    ord      = '{3, 1, 0, 2};
    ri = 0; nf = 0; cyc = 0;
    while (nf < 4 && cyc < 100) begin
      @(negedge clk);
      idle();
      bus.fill_ready    = ((cyc % 2) == 1);
      bus.mem_rsp_valid = (ri < 4);
      if (ri < 4) begin
        bus.mem_rsp_tag  = 2'(ord[ri]);
        bus.mem_rsp_data = {16{32'hC0DE0000 + 32'(ord[ri])}};
      end
      #1;
      if (bus.fill_valid && bus.fill_ready) begin
        if (qa.size() == 0) begin
          chk("t4.unexpected_fill", 512'(1), 512'(0));
        end else begin
          chk($sformatf("t4.fill%0d.addr", nf), 512'(bus.fill_addr), 512'(qa[0]));
          chk($sformatf("t4.fill%0d.data", nf), bus.fill_data, qd[0]);
          chk($sformatf("t4.fill%0d.lookup", nf), 512'({bus.lookup_ready, bus.lookup_addr}),
              512'({1'b1, qa[0]}));
          void'(qa.pop_front());
          void'(qd.pop_front());
          nf++;
        end
      end
      if (bus.mem_rsp_valid && bus.mem_rsp_ready) begin
        qa.push_back(tag_addr[ord[ri]]);
        qd.push_back({16{32'hC0DE0000 + 32'(ord[ri])}});
        ri++;
      end
      cyc++;
    end
    chk("t4.fills_delivered", 512'(nf), 512'(4));
    @(negedge clk);
    idle();
    #1;
    chk("t4.pending_drained", 512'(bus.pending_count), 512'(0));

    // Asynchronous reset with three lines in flight and one waiting
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle();
      bus.fill_req_valid = 1'b1;
      bus.fill_req_addr  = 26'h30 + 26'(k);
      bus.mem_req_ready  = 1'b1;
    end
    @(negedge clk);
    idle();
    #1;
    chk("t6.pre_reset", 512'({bus.pending_count, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_tag}),
        512'({3'd4, 1'b1, 26'h33, 2'd3}));
    #2;
    reset = 1'b0;
    #1;
    chk("t6.in_reset", 512'({bus.pending_count, bus.mem_req_valid, bus.fill_valid, bus.fill_req_ready}),
        512'({3'd0, 1'b0, 1'b0, 1'b1}));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6.released", 512'({bus.pending_count, bus.mem_req_valid, bus.fill_req_ready, bus.fill_addr}),
        512'({3'd0, 1'b0, 1'b1, 26'h0}));
    @(negedge clk);
    bus.fill_req_valid = 1'b1;
    bus.fill_req_addr  = 26'h40;
    @(negedge clk);
    idle();
    #1;
    chk("t6.realloc", 512'({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_tag, bus.pending_count}),
        512'({1'b1, 26'h40, 2'd0, 3'd1}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
